// File: rtl/dcm_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50%-duty divided
// clock plus a rise-aligned tick, with ratio changes deferred to the end of a full period.
module dcm_multi #(
    parameter int NUM_CH     = 2,
    parameter int BASE_COUNT = 5_000_000,
    parameter int CW         = 32,
    parameter int CHW        = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  update,
    input  logic [CHW-1:0]        update_ch,
    input  logic [2:0]            prog_in,
    input  logic [NUM_CH-1:0]     enable,
    output logic [NUM_CH-1:0]     clk_out,
    output logic [NUM_CH-1:0]     tick,
    output logic [3*NUM_CH-1:0]   prog_out,
    output logic [NUM_CH-1:0]     pending
);

    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]         clkOut_q, clkOut_d;
    logic [NUM_CH-1:0]         tick_q, tick_d;
    logic [NUM_CH-1:0][2:0]    applied_q, applied_d;
    logic [NUM_CH-1:0][2:0]    pendCode_q, pendCode_d;
    logic [NUM_CH-1:0]         pending_q, pending_d;

    function automatic logic [CW-1:0] halfPeriod(input logic [2:0] code);
        logic [CW-1:0] base;
        logic [CW-1:0] mult;
        base = CW'(BASE_COUNT);
        case (code)
            3'd0:    mult = CW'(1);
            3'd1:    mult = CW'(2);
            3'd2:    mult = CW'(4);
            3'd3:    mult = CW'(10);
            3'd4:    mult = CW'(16);
            3'd5:    mult = CW'(32);
            3'd6:    mult = CW'(64);
            default: mult = CW'(128);
        endcase
        return base * mult;
    endfunction

    // The apply boundary is the wrap that drives clk_out low, so a new ratio always
    // starts on a fresh low phase and never produces a runt pulse.
    always_comb begin
        logic          hit;
        logic [CW-1:0] lastCnt;
        cnt_d      = cnt_q;
        clkOut_d   = clkOut_q;
        tick_d     = '0;
        applied_d  = applied_q;
        pendCode_d = pendCode_q;
        pending_d  = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            hit     = update && (32'(update_ch) == i);
            lastCnt = halfPeriod(applied_q[i]) - CW'(1);
            if (!enable[i]) begin
                cnt_d[i]    = '0;
                clkOut_d[i] = 1'b0;
                if (hit) begin
                    applied_d[i] = prog_in;
                    pending_d[i] = 1'b0;
                end else if (pending_q[i]) begin
                    applied_d[i] = pendCode_q[i];
                    pending_d[i] = 1'b0;
                end
            end else if (cnt_q[i] == lastCnt) begin
                cnt_d[i]    = '0;
                clkOut_d[i] = ~clkOut_q[i];
                tick_d[i]   = ~clkOut_q[i];
                if (clkOut_q[i]) begin
                    if (hit) begin
                        applied_d[i] = prog_in;
                        pending_d[i] = 1'b0;
                    end else if (pending_q[i]) begin
                        applied_d[i] = pendCode_q[i];
                        pending_d[i] = 1'b0;
                    end
                end else if (hit) begin
                    pendCode_d[i] = prog_in;
                    pending_d[i]  = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
                if (hit) begin
                    pendCode_d[i] = prog_in;
                    pending_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            clkOut_q   <= '0;
            tick_q     <= '0;
            applied_q  <= '0;
            pendCode_q <= '0;
            pending_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            clkOut_q   <= clkOut_d;
            tick_q     <= tick_d;
            applied_q  <= applied_d;
            pendCode_q <= pendCode_d;
            pending_q  <= pending_d;
        end
    end

    assign clk_out  = clkOut_q;
    assign tick     = tick_q;
    assign prog_out = applied_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_dcm_multi.sv
// Bench for dcm_multi: expected tick cycles are queued per channel as stimulus is applied
// and matched against observed ticks; a one-channel instance checks out-of-range updates.
module tb_dcm_multi;

    logic       clock;
    logic       reset;
    logic       update;
    logic [0:0] update_ch;
    logic [2:0] prog_in;
    logic [1:0] enable;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [5:0] prog_out;
    logic [1:0] pending;

    logic [0:0] enable1;
    logic [0:0] clkOut1;
    logic [0:0] tick1;
    logic [2:0] progOut1;
    logic [0:0] pending1;

    int cyc = 0;
    int checkCount = 0;
    int errorCount = 0;
    int expQ0[$];
    int expQ1[$];

    dcm_multi #(.NUM_CH(2), .BASE_COUNT(4), .CW(16), .CHW(1)) dut (
        .clock(clock), .reset(reset), .update(update), .update_ch(update_ch),
        .prog_in(prog_in), .enable(enable), .clk_out(clk_out), .tick(tick),
        .prog_out(prog_out), .pending(pending)
    );

    dcm_multi #(.NUM_CH(1), .BASE_COUNT(4), .CW(16), .CHW(1)) dut1 (
        .clock(clock), .reset(reset), .update(update), .update_ch(update_ch),
        .prog_in(prog_in), .enable(enable1), .clk_out(clkOut1), .tick(tick1),
        .prog_out(progOut1), .pending(pending1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic doUpdate, input logic [0:0] ch, input logic [2:0] code,
                                 input logic [1:0] en);
        update    = doUpdate;
        update_ch = ch;
        prog_in   = code;
        enable    = en;
    endtask

    task automatic pushRises(input int ch, input int first, input int step, input int count);
        for (int k = 0; k < count; k++) begin
            if (ch == 0) expQ0.push_back(first + k * step);
            else         expQ1.push_back(first + k * step);
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Every observed tick must match the next queued rise time; unexpected ticks fail.
    always @(negedge clock) begin
        if (tick[0]) begin
            if (expQ0.size() > 0) checkOutput("tick0", cyc, expQ0.pop_front());
            else                  checkOutput("tick0 extra", cyc, 32'hFFFF_FFFF);
        end
        if (tick[1]) begin
            if (expQ1.size() > 0) checkOutput("tick1", cyc, expQ1.pop_front());
            else                  checkOutput("tick1 extra", cyc, 32'hFFFF_FFFF);
        end
    end

    initial begin
        reset   = 1'b1;
        enable1 = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00);
        #2 reset = 1'b0;
        stepTo(2);
        checkOutput("rst clk_out", 32'(clk_out), 0);
        checkOutput("rst tick", 32'(tick), 0);
        checkOutput("rst prog_out", 32'(prog_out), 0);
        checkOutput("rst pending", 32'(pending), 0);
        checkOutput("rst nc1 prog", 32'(progOut1), 0);

        // Both channels at multiplier 1: H=4, rises at 6 + 8k.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11);
        pushRises(0, 6, 8, 4);
        pushRises(1, 6, 8, 10);
        stepTo(9);
        checkOutput("clk high", 32'(clk_out), 3);
        stepTo(10);
        checkOutput("clk fall", 32'(clk_out), 0);

        // Deferred ratio change on ch0 during its high phase.
        stepTo(31);
        applyStimulus(1'b1, 1'b0, 3'd1, 2'b11);
        pushRises(0, 42, 16, 5);
        stepTo(32);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11);
        checkOutput("pend0 set", 32'(pending), 1);
        stepTo(33);
        checkOutput("prog0 wait", 32'(prog_out), 0);
        checkOutput("nc1 direct", 32'(progOut1), 1);
        stepTo(34);
        checkOutput("pend0 clr", 32'(pending), 0);
        checkOutput("prog0 app", 32'(prog_out), 1);

        // Two updates to ch1 before its boundary: the last one wins.
        stepTo(78);
        applyStimulus(1'b1, 1'b1, 3'd3, 2'b11);
        stepTo(79);
        applyStimulus(1'b1, 1'b1, 3'd7, 2'b11);
        pushRises(1, 594, 1024, 2);
        stepTo(80);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11);
        stepTo(81);
        checkOutput("pend1 set", 32'(pending), 2);
        checkOutput("prog1 wait", 32'(prog_out), 1);
        stepTo(82);
        checkOutput("pend1 clr", 32'(pending), 0);
        checkOutput("prog1 app", 32'(prog_out), 57);
        checkOutput("nc1 ignore prog", 32'(progOut1), 1);
        checkOutput("nc1 ignore pend", 32'(pending1), 0);

        // Disable ch0 mid high phase, reprogram while idle, then re-enable.
        stepTo(108);
        checkOutput("ch0 high", 32'(clk_out[0]), 1);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b10);
        stepTo(109);
        checkOutput("ch0 forced low", 32'(clk_out[0]), 0);
        stepTo(112);
        applyStimulus(1'b1, 1'b0, 3'd2, 2'b10);
        stepTo(113);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b10);
        checkOutput("prog dis app", 32'(prog_out), 58);
        checkOutput("pend dis", 32'(pending), 0);
        stepTo(120);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11);
        pushRises(0, 136, 32, 2);

        // Update landing exactly on ch0's falling boundary at edge 184.
        stepTo(183);
        applyStimulus(1'b1, 1'b0, 3'd0, 2'b11);
        pushRises(0, 188, 8, 180);
        stepTo(184);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11);
        checkOutput("bnd prog", 32'(prog_out), 56);
        checkOutput("bnd pend", 32'(pending), 0);
        checkOutput("bnd clk0", 32'(clk_out[0]), 0);
        stepTo(185);
        checkOutput("bnd pend next", 32'(pending), 0);

        // Asynchronous reset while ch0 has a pending code and a live tick.
        stepTo(1625);
        applyStimulus(1'b1, 1'b0, 3'd1, 2'b11);
        stepTo(1626);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11);
        stepTo(1627);
        checkOutput("pre rst pend", 32'(pending), 1);
        stepTo(1628);
        checkOutput("pre rst tick", 32'(tick), 1);
        reset = 1'b0;
        #1;
        checkOutput("mid rst clk_out", 32'(clk_out), 0);
        checkOutput("mid rst tick", 32'(tick), 0);
        checkOutput("mid rst prog_out", 32'(prog_out), 0);
        checkOutput("mid rst pending", 32'(pending), 0);
        stepTo(1630);
        reset = 1'b1;
        pushRises(0, 1634, 8, 3);
        pushRises(1, 1634, 8, 3);
        stepTo(1632);
        checkOutput("post rst prog", 32'(prog_out), 0);
        stepTo(1655);
        checkOutput("tick0 missing", expQ0.size(), 0);
        checkOutput("tick1 missing", expQ1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
